// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time IMEM loader.
package imem_loader_pkg;

    // Frame start marker on the host link.
    localparam logic [7:0] LOADER_MAGIC = 8'hA5;

    // Width of the IMEM byte address and write data buses.
    localparam int IMEM_ADDR_W = 32;

    typedef enum logic [2:0] {
        S_MAGIC,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERROR
    } loader_state_t;

    // The loader takes bytes in every state except the two terminal ones.
    function automatic logic state_accepts(loader_state_t s);
        return (s != S_DONE) && (s != S_ERROR);
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Host byte link plus IMEM write port of the boot loader.
// Link handshake: a byte moves on a rising clk edge where rx_valid and
// rx_ready are both high; rx_data is don't-care in any other cycle and the
// source may raise or drop rx_valid freely between transfers.
interface imem_loader_if;
    import imem_loader_pkg::*;

    logic                   rx_valid;
    logic [7:0]             rx_data;
    logic                   rx_ready;
    logic                   imem_we;
    logic [IMEM_ADDR_W-1:0] imem_addr;
    logic [IMEM_ADDR_W-1:0] imem_wdata;

    // Host side: sources bytes and observes the IMEM write port.
    modport master (
        output rx_valid,
        output rx_data,
        input  rx_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );

    // Loader side: sinks bytes and drives the IMEM write port.
    modport slave (
        input  rx_valid,
        input  rx_data,
        output rx_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );

endinterface

// File: rtl/imem_loader.sv
// Boot-time IMEM writer: parses a framed little-endian byte stream, writes
// 32-bit words from address 0 upward and releases the core reset only after
// the whole frame has landed and its XOR checksum matches.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int IMEM_DEPTH = 1024
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          restart,
    imem_loader_if.slave  bus,
    output logic          core_rst_n,
    output logic          load_done,
    output logic          load_error,
    output loader_state_t state
);

    localparam int          IDX_W       = $clog2(IMEM_DEPTH) + 1;
    localparam int          PAD_W       = IMEM_ADDR_W - IDX_W - 2;
    localparam logic [16:0] DEPTH_LIMIT = 17'(IMEM_DEPTH);

    logic                   rdy_q;
    logic [15:0]            len;
    logic [IDX_W-1:0]       word_idx;
    logic [1:0]             byte_cnt;
    logic [7:0]             csum;
    logic [23:0]            word_buf;
    logic                   we_q;
    logic [IMEM_ADDR_W-1:0] addr_q;
    logic [IMEM_ADDR_W-1:0] wdata_q;

    logic accept;
    logic word_end;
    logic last_word;
    logic len_too_big;
    logic len_zero;

    // restart wins over any byte: it masks ready in the same cycle.
    assign accept      = bus.rx_valid && rdy_q && !restart;
    assign word_end    = (byte_cnt == 2'd3);
    assign last_word   = ((16'(word_idx) + 16'd1) == len);
    // Length checks use the high byte as it arrives together with the latched low byte.
    assign len_too_big = ({1'b0, bus.rx_data, len[7:0]} > DEPTH_LIMIT);
    assign len_zero    = ({bus.rx_data, len[7:0]} == 16'd0);

    assign bus.rx_ready   = rdy_q && !restart;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;

    // Frame-level control: state, link ready and the sticky status/reset outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_MAGIC;
            rdy_q      <= 1'b0;
            core_rst_n <= 1'b0;
            load_done  <= 1'b0;
            load_error <= 1'b0;
        end else if (restart) begin
            state      <= S_MAGIC;
            rdy_q      <= 1'b1;
            core_rst_n <= 1'b0;
            load_done  <= 1'b0;
            load_error <= 1'b0;
        end else begin
            rdy_q <= state_accepts(state);
            if (accept) begin
                case (state)
                    S_MAGIC: begin
                        if (bus.rx_data == LOADER_MAGIC) begin
                            state <= S_LEN_LO;
                        end
                    end
                    S_LEN_LO: begin
                        state <= S_LEN_HI;
                    end
                    S_LEN_HI: begin
                        if (len_too_big) begin
                            state      <= S_ERROR;
                            rdy_q      <= 1'b0;
                            load_error <= 1'b1;
                        end else if (len_zero) begin
                            state <= S_CSUM;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        if (word_end && last_word) begin
                            state <= S_CSUM;
                        end
                    end
                    S_CSUM: begin
                        rdy_q <= 1'b0;
                        if (bus.rx_data == csum) begin
                            state      <= S_DONE;
                            load_done  <= 1'b1;
                            core_rst_n <= 1'b1;
                        end else begin
                            state      <= S_ERROR;
                            load_error <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Datapath: length latch, word assembler, checksum, word counter and IMEM write strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len      <= '0;
            word_idx <= '0;
            byte_cnt <= '0;
            csum     <= '0;
            word_buf <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            we_q <= 1'b0;
            if (restart) begin
                len      <= '0;
                word_idx <= '0;
                byte_cnt <= '0;
                csum     <= '0;
            end else if (accept) begin
                case (state)
                    S_LEN_LO: len[7:0]  <= bus.rx_data;
                    S_LEN_HI: len[15:8] <= bus.rx_data;
                    S_DATA: begin
                        csum     <= csum ^ bus.rx_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        case (byte_cnt)
                            2'd0: word_buf[7:0]   <= bus.rx_data;
                            2'd1: word_buf[15:8]  <= bus.rx_data;
                            2'd2: word_buf[23:16] <= bus.rx_data;
                            default: begin
                                // Fourth byte completes the word; it is written next cycle.
                                we_q     <= 1'b1;
                                wdata_q  <= {bus.rx_data, word_buf};
                                addr_q   <= {{PAD_W{1'b0}}, word_idx, 2'b00};
                                word_idx <= word_idx + 1'b1;
                            end
                        endcase
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frames plus randomized
// frames, checked against a frame-level parsing model and a write scoreboard.
`timescale 1ns/1ps
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int IMEM_DEPTH = 1024;
    localparam int M_OPEN     = 0;
    localparam int M_DONE     = 1;
    localparam int M_ERROR    = 2;

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          restart = 1'b0;
    logic          core_rst_n;
    logic          load_done;
    logic          load_error;
    loader_state_t state;

    imem_loader_if bus ();

    imem_loader #(.IMEM_DEPTH(IMEM_DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .restart    (restart),
        .bus        (bus),
        .core_rst_n (core_rst_n),
        .load_done  (load_done),
        .load_error (load_error),
        .state      (state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_errors = 0;
    int          stall_cnt = 0;
    logic [63:0] exp_q[$];    // {addr, data} of every expected IMEM write, in order
    int          lat_q[$];    // cycle in which each expected write must appear
    int          end_idx[$];  // frame byte indices that complete a word
    logic [7:0]  frame_q[$];  // byte stream of the frame under test

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Every IMEM write must match the head of the expected queue, one cycle after its 4th byte.
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 64'(exp_q.size()), 64'd1);
            end else begin
                check("write", {bus.imem_addr, bus.imem_wdata}, exp_q.pop_front());
                if (lat_q.size() > 0) check("write_latency", 64'(cyc), 64'(lat_q.pop_front()));
            end
        end
    end

    // ---------------- reference model ----------------
    // Parses frame_q as the host intends it: skip to the magic, read N, then N
    // little-endian words and the XOR checksum. Complete words become expected writes.
    task automatic model_frame(output int status);
        int         i;
        int         n;
        int         sz;
        logic [7:0] x;
        logic [31:0] w;
        status = M_OPEN;
        end_idx.delete();
        sz = frame_q.size();
        i = 0;
        while (i < sz && frame_q[i] != LOADER_MAGIC) i++;
        if (i + 3 > sz) return;
        n = int'(frame_q[i+1]) + 256 * int'(frame_q[i+2]);
        i += 3;
        if (n > IMEM_DEPTH) begin
            status = M_ERROR;
            return;
        end
        x = 8'h00;
        for (int k = 0; k < n; k++) begin
            if (i + 4 > sz) return;
            w = 32'(frame_q[i]) + 32'(frame_q[i+1]) * 32'd256
              + 32'(frame_q[i+2]) * 32'd65536 + 32'(frame_q[i+3]) * 32'd16777216;
            x = x ^ frame_q[i] ^ frame_q[i+1] ^ frame_q[i+2] ^ frame_q[i+3];
            exp_q.push_back({32'(4 * k), w});
            end_idx.push_back(i + 3);
            i += 4;
        end
        if (i >= sz) return;
        status = (frame_q[i] == x) ? M_DONE : M_ERROR;
    endtask

    // Random frame: optional noise (never the magic), N words, checksum optionally corrupted.
    task automatic build_frame(input int n_noise, input int n, input bit bad);
        logic [7:0] b;
        logic [7:0] x;
        frame_q.delete();
        for (int i = 0; i < n_noise; i++) begin
            do b = 8'($urandom); while (b == LOADER_MAGIC);
            frame_q.push_back(b);
        end
        frame_q.push_back(LOADER_MAGIC);
        frame_q.push_back(8'(n));
        frame_q.push_back(8'(n >> 8));
        x = 8'h00;
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom);
            x = x ^ b;
            frame_q.push_back(b);
        end
        if (bad) x = x ^ 8'($urandom_range(1, 255));
        frame_q.push_back(x);
    endtask

    // ---------------- driver tasks ----------------
    // All driver tasks start and end 1 ns after a rising edge.
    task automatic send_byte(input logic [7:0] b, input bit is_end, input int gap);
        bit taken;
        taken = 1'b0;
        if (gap > 0) begin
            bus.rx_valid = 1'b0;
            bus.rx_data  = 8'($urandom);
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
        end
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        for (int t = 0; t < 16 && !taken; t++) begin
            @(negedge clk);
            if (bus.rx_ready) begin
                taken = 1'b1;
                check("busy_flags", 64'({load_done, core_rst_n}), 64'd0);
                if (is_end) lat_q.push_back(cyc + 1);
            end else begin
                stall_cnt++;
            end
            @(posedge clk);
            #1;
        end
        if (!taken) check("rx_ready_timeout", 64'(taken), 64'd1);
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_frame(input bit full_rate, input int max_gap);
        int  s0;
        int  g;
        bit  e;
        s0 = stall_cnt;
        for (int i = 0; i < frame_q.size(); i++) begin
            e = (end_idx.size() > 0 && end_idx[0] == i);
            if (e) void'(end_idx.pop_front());
            g = full_rate ? 0 : int'($urandom_range(0, max_gap));
            send_byte(frame_q[i], e, g);
        end
        if (full_rate) check("full_rate_stalls", 64'(stall_cnt - s0), 64'd0);
    endtask

    task automatic check_status(input int st);
        bus.rx_valid = 1'b0;
        @(negedge clk);
        check("load_done", 64'(load_done), 64'(st == M_DONE));
        check("load_error", 64'(load_error), 64'(st == M_ERROR));
        check("core_rst_n", 64'(core_rst_n), 64'(st == M_DONE));
        check("rx_ready_after", 64'(bus.rx_ready), 64'(st == M_OPEN));
        check("writes_left", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values();
        @(negedge clk);
        check("rst_rx_ready", 64'(bus.rx_ready), 64'd0);
        check("rst_imem_we", 64'(bus.imem_we), 64'd0);
        check("rst_imem_addr", 64'(bus.imem_addr), 64'd0);
        check("rst_imem_wdata", 64'(bus.imem_wdata), 64'd0);
        check("rst_core_rst_n", 64'(core_rst_n), 64'd0);
        check("rst_load_done", 64'(load_done), 64'd0);
        check("rst_load_error", 64'(load_error), 64'd0);
        check("rst_state", 64'(state), 64'(S_MAGIC));
    endtask

    // Pulse restart with a magic byte offered in the same cycle; it must not be taken.
    task automatic do_restart();
        restart      = 1'b1;
        bus.rx_valid = 1'b1;
        bus.rx_data  = LOADER_MAGIC;
        @(negedge clk);
        check("restart_blocks_rx", 64'(bus.rx_ready), 64'd0);
        @(posedge clk);
        #1;
        restart      = 1'b0;
        bus.rx_valid = 1'b0;
        @(negedge clk);
        check("restart_done", 64'(load_done), 64'd0);
        check("restart_error", 64'(load_error), 64'd0);
        check("restart_core_rst_n", 64'(core_rst_n), 64'd0);
        check("restart_rx_ready", 64'(bus.rx_ready), 64'd1);
        check("restart_writes_left", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int st;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Good two-word frame; XOR of the payload bytes is 0x90.
        frame_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                    8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
        model_frame(st);
        check("model_good_writes", 64'(exp_q.size()), 64'd2);
        send_frame(1'b1, 0);
        check_status(M_DONE);
        check("state_done", 64'(state), 64'(S_DONE));

        // Same frame with a wrong checksum.
        do_restart();
        frame_q[frame_q.size() - 1] = 8'h81;
        model_frame(st);
        send_frame(1'b1, 0);
        check_status(M_ERROR);

        // Noise ahead of a good frame.
        do_restart();
        frame_q = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                    8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
        model_frame(st);
        send_frame(1'b1, 0);
        check_status(M_DONE);

        // Oversized length: rejected right after the high length byte.
        do_restart();
        frame_q = '{8'hA5, 8'h01, 8'h04};
        model_frame(st);
        send_frame(1'b1, 0);
        check_status(M_ERROR);

        // Empty frame.
        do_restart();
        frame_q = '{8'hA5, 8'h00, 8'h00, 8'h00};
        model_frame(st);
        send_frame(1'b1, 0);
        check_status(M_DONE);

        // Abort after 6 payload bytes: one word lands, then a fresh frame restarts at 0.
        do_restart();
        frame_q = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        model_frame(st);
        send_frame(1'b1, 0);
        do_restart();
        build_frame(0, 3, 1'b0);
        model_frame(st);
        send_frame(1'b1, 0);
        check_status(st);

        // rst_n mid-frame behaves like power-on reset.
        do_restart();
        frame_q = '{8'hA5, 8'h03, 8'h00, 8'hAA, 8'hBB};
        model_frame(st);
        send_frame(1'b1, 0);
        rst_n = 1'b0;
        check_reset_values();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        build_frame(1, 3, 1'b0);
        model_frame(st);
        send_frame(1'b1, 0);
        check_status(st);

        // Largest legal frame fills the whole IMEM.
        do_restart();
        build_frame(0, IMEM_DEPTH, 1'b0);
        model_frame(st);
        send_frame(1'b1, 0);
        check_status(st);

        // Randomized frames with noise, gaps and corrupt checksums.
        for (int it = 0; it < 24; it++) begin
            do_restart();
            build_frame(int'($urandom_range(0, 3)), int'($urandom_range(0, 6)),
                        $urandom_range(0, 3) == 0);
            model_frame(st);
            send_frame(it[0], 3);
            check_status(st);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
